syscall_sequencer: RTL and testbench
====================================

# syscall_sequencer

Synchronous controller that services the CPU's SYSCALL instruction and sequences the pipeline's halt/resume. It decodes the service number in v0 and does one of three things: latches a0 into the display register, pauses the CPU until the GO button is pressed, or stops the CPU until the next clear. It sits beside the WB stage, drives the global `halt` that freezes the pipeline, and feeds the seven-segment display driver.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the GO synchronizer; minimum 2.
- `DW`, default 32: width of v0, a0 and display.

Ports:
- `clk` input, 1: the single system clock. All state changes on its rising edge.
- `CLR` input, 1: reset, synchronous and active-high.
- `SYSCALL` input, 1: single-cycle pulse, qualified by WB, indicating that a syscall retires this cycle.
- `GO` input, 1: raw, asynchronous level from the push button.
- `v0` input, DW: service number, valid while `SYSCALL` is high.
- `a0` input, DW: service argument, valid while `SYSCALL` is high.
- `display` output, DW: last value printed.
- `disp_upd` output, 1: one-cycle pulse, high in the cycle after `display` is written.
- `halt` output, 1: pipeline freeze, registered.
- `exited` output, 1: high while in state EXITED.
- `sys_count` output, 32: number of syscalls serviced. Feature-gated; see Configuration.
- `halt_cycles` output, 32: number of cycles with `halt` high. Feature-gated; see Configuration.

## Operation
- Reset (`CLR` high at an edge):
  - state goes to RUN.
  - `display`, `disp_upd`, `halt`, `exited`, both counters and the synchronizer/edge flops are all cleared to 0.
- States are RUN, PAUSED and EXITED.
- In RUN, `SYSCALL` high at an edge is decoded on v0:
  - v0 == PRINT_CODE (34): `display` <= a0, `disp_upd` pulses, state stays RUN, `halt` stays 0.
  - v0 == EXIT_CODE (10): state goes to EXITED; `halt` and `exited` are set to 1.
  - Any other value: state goes to PAUSED and `halt` is set to 1.
- In PAUSED:
  - a GO rising-edge pulse (`go_rise`) returns the state to RUN and clears `halt`.
  - `SYSCALL` is ignored (the pipeline is frozen).
- In EXITED: `GO` and `SYSCALL` are ignored; only `CLR` leaves this state.
- GO handling:
  - `GO` passes through SYNC_STAGES flops, then a rising-edge detector that produces a one-cycle `go_rise`.
  - Holding the button produces exactly one pulse.
  - A `go_rise` arriving in RUN or EXITED is discarded and is not remembered.
- Simultaneous events:
  - `CLR` beats everything.
  - In RUN, `SYSCALL` and `go_rise` at the same edge: the syscall is serviced and `go_rise` is discarded.
  - In PAUSED, `SYSCALL` and `go_rise` at the same edge: the resume happens and `SYSCALL` is dropped.
- Comparisons of v0 are full DW-bit equality, so upper bits must match.

## Timing
- The `SYSCALL` edge E sets `halt`, `exited` and `display` visible at E+1 (one cycle latency); `disp_upd` is high for the cycle E to E+1 only.
- GO latency: with `GO` first sampled high at edge G, `go_rise` is high after edge G+SYNC_STAGES, and `halt` falls at edge G+SYNC_STAGES+1 (at G+3 for the default).
- `CLR` held over several cycles keeps all outputs at 0. A `CLR` arriving mid-pause or mid-exit gives `halt` = 0 on the next edge.
- `halt` never glitches because it is driven directly from a flop.

## Configuration
- `SYSCALL_STATS_EN` defined:
  - `sys_count` increments on every serviced syscall, which covers every `SYSCALL` accepted in RUN.
  - `halt_cycles` increments on every edge at which `halt` is 1.
  - Both counters wrap modulo 2^32 and are cleared by `CLR`.
- Not defined: both ports remain in the interface, tied to 0, and no counter flops are built.

## Structure
- Package `syscall_pkg` holds:
  - `PRINT_CODE` = 34 and `EXIT_CODE` = 10.
  - the state enum `sc_state_t` with values RUN, PAUSED, EXITED.
- Sub-module `go_edge_sync` (synchronizer plus rising-edge detect, parameter SYNC_STAGES, ports clk, CLR, GO, go_rise). It is reused by other button inputs on the board.

## Test plan
- Print: `CLR`, then `SYSCALL` with v0=34, a0=0x1234_ABCD -> next cycle `display`=0x1234ABCD, `disp_upd`=1 for exactly one cycle, `halt` stays 0.
- Pause/resume: `SYSCALL` with v0=5 -> `halt`=1 at E+1; `GO` held high for 10 cycles -> `halt` falls exactly SYNC_STAGES+1 edges after `GO` is first sampled; a second `SYSCALL` v0=5 halts again without `GO` being released first, and stays halted.
- Exit: `SYSCALL` with v0=10 -> `halt`=1 and `exited`=1; five separate `GO` presses leave both at 1; `CLR` -> both 0 on the next edge.
- Collisions: in RUN, `SYSCALL` v0=5 on the same edge as `go_rise` -> PAUSED with `halt`=1; in PAUSED, `SYSCALL` on the same edge as `go_rise` -> RUN and `sys_count` unchanged.
- Reset mid-pause: PAUSED, then `CLR` for 1 cycle -> `halt`=0, `display`=0, and a later `GO` press has no effect.
- Stats (`SYSCALL_STATS_EN` defined): 3 syscalls (34, 5, then resume, then 34) and a pause lasting 20 cycles -> `sys_count`=3 and `halt_cycles`=20 + the GO latency; without the macro both ports read 0 throughout.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared service codes and controller state encoding for the syscall sequencer.
`timescale 1ns/1ps
package syscall_pkg;

  localparam int unsigned PRINT_CODE = 34;
  localparam int unsigned EXIT_CODE  = 10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    EXITED = 2'd2
  } sc_state_t;

endpackage

// File: rtl/go_edge_sync.sv
// Multi-flop synchronizer for a raw push-button level followed by a registered
// rising-edge detector; emits one go_rise pulse per press. Shared by board buttons.
`timescale 1ns/1ps
module go_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic CLR,
  input  logic GO,
  output logic go_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain shift.
  always_ff @(posedge clk) begin
    if (CLR) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], GO};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign go_rise = rise_q;

endmodule

// File: rtl/syscall_sequencer.sv
// SYSCALL service controller: print / pause-until-GO / exit, driving the pipeline halt.
// Optional statistics counters are built only when SYSCALL_STATS_EN is defined.
`timescale 1ns/1ps
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          SYSCALL,
  input  logic          GO,
  input  logic [DW-1:0] v0,
  input  logic [DW-1:0] a0,
  output logic [DW-1:0] display,
  output logic          disp_upd,
  output logic          halt,
  output logic          exited,
  output logic [31:0]   sys_count,
  output logic [31:0]   halt_cycles
);

  localparam logic [DW-1:0] PRINT_V = DW'(PRINT_CODE);
  localparam logic [DW-1:0] EXIT_V  = DW'(EXIT_CODE);

  sc_state_t     state_q;
  logic [DW-1:0] display_q;
  logic          disp_upd_q;
  logic          halt_q;
  logic          exited_q;
  logic          go_rise;

  go_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_go_sync (
    .clk     (clk),
    .CLR     (CLR),
    .GO      (GO),
    .go_rise (go_rise)
  );

  // A go_rise outside PAUSED and a SYSCALL outside RUN simply fall through.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q    <= RUN;
      display_q  <= '0;
      disp_upd_q <= 1'b0;
      halt_q     <= 1'b0;
      exited_q   <= 1'b0;
    end else begin
      disp_upd_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (SYSCALL) begin
            if (v0 == PRINT_V) begin
              display_q  <= a0;
              disp_upd_q <= 1'b1;
            end else if (v0 == EXIT_V) begin
              state_q  <= EXITED;
              halt_q   <= 1'b1;
              exited_q <= 1'b1;
            end else begin
              state_q <= PAUSED;
              halt_q  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (go_rise) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
          end
        end
        EXITED: begin
        end
        default: begin
          state_q  <= RUN;
          halt_q   <= 1'b0;
          exited_q <= 1'b0;
        end
      endcase
    end
  end

  assign display  = display_q;
  assign disp_upd = disp_upd_q;
  assign halt     = halt_q;
  assign exited   = exited_q;

`ifdef SYSCALL_STATS_EN
  logic [31:0] sys_count_q;
  logic [31:0] halt_cycles_q;

  always_ff @(posedge clk) begin
    if (CLR) begin
      sys_count_q   <= '0;
      halt_cycles_q <= '0;
    end else begin
      if (SYSCALL && (state_q == RUN)) sys_count_q <= sys_count_q + 32'd1;
      if (halt_q) halt_cycles_q <= halt_cycles_q + 32'd1;
    end
  end

  assign sys_count   = sys_count_q;
  assign halt_cycles = halt_cycles_q;
`else
  assign sys_count   = 32'd0;
  assign halt_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_syscall_sequencer.sv
// Self-checking bench for syscall_sequencer: directed scenarios plus a randomized
// phase, all compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_syscall_sequencer;

  localparam int S  = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          CLR = 1'b0;
  logic          SYSCALL = 1'b0;
  logic          GO = 1'b0;
  logic [DW-1:0] v0 = '0;
  logic [DW-1:0] a0 = '0;
  logic [DW-1:0] display;
  logic          disp_upd;
  logic          halt;
  logic          exited;
  logic [31:0]   sys_count;
  logic [31:0]   halt_cycles;

  syscall_sequencer #(.SYNC_STAGES(S), .DW(DW)) dut (
    .clk         (clk),
    .CLR         (CLR),
    .SYSCALL     (SYSCALL),
    .GO          (GO),
    .v0          (v0),
    .a0          (a0),
    .display     (display),
    .disp_upd    (disp_upd),
    .halt        (halt),
    .exited      (exited),
    .sys_count   (sys_count),
    .halt_cycles (halt_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what a user of the controller expects to observe.
  bit          m_valid = 1'b0;
  bit          m_paused, m_exited, m_upd;
  logic [31:0] m_display, m_cnt, m_hcyc;
  bit          g_hist [0:S+1];   // g_hist[k] = GO as sampled k+1 edges ago

  function automatic void model_edge(input bit clr, input bit sc, input bit go,
                                     input logic [31:0] v, input logic [31:0] a);
    bit rise;
    rise = g_hist[S] && !g_hist[S+1];
    if (clr) begin
      m_valid = 1'b1;
      m_paused = 1'b0; m_exited = 1'b0; m_upd = 1'b0;
      m_display = '0; m_cnt = '0; m_hcyc = '0;
      for (int i = 0; i <= S+1; i++) g_hist[i] = 1'b0;
      return;
    end
    for (int i = S+1; i >= 1; i--) g_hist[i] = g_hist[i-1];
    g_hist[0] = go;
    if (m_paused || m_exited) m_hcyc = m_hcyc + 1;
    m_upd = 1'b0;
    if (m_exited) begin
    end else if (m_paused) begin
      if (rise) m_paused = 1'b0;
    end else if (sc) begin
      m_cnt = m_cnt + 1;
      if (v == 32'd34) begin
        m_display = a;
        m_upd = 1'b1;
      end else if (v == 32'd10) begin
        m_exited = 1'b1;
      end else begin
        m_paused = 1'b1;
      end
    end
  endfunction

  // Single compare process, every cycle once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      check("display",  display,  m_display);
      check("disp_upd", {31'd0, disp_upd}, {31'd0, m_upd});
      check("halt",     {31'd0, halt},     {31'd0, (m_paused || m_exited)});
      check("exited",   {31'd0, exited},   {31'd0, m_exited});
`ifdef SYSCALL_STATS_EN
      check("sys_count",   sys_count,   m_cnt);
      check("halt_cycles", halt_cycles, m_hcyc);
`else
      check("sys_count",   sys_count,   32'd0);
      check("halt_cycles", halt_cycles, 32'd0);
`endif
    end
  end

  task automatic step(input bit clr, input bit sc, input bit go,
                      input logic [31:0] v, input logic [31:0] a);
    CLR = clr; SYSCALL = sc; GO = go; v0 = v; a0 = a;
    @(posedge clk);
    model_edge(clr, sc, go, v, a);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit go);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, go, 32'd0, 32'd0);
  endtask

  task automatic press();
    idle(4, 1'b1);
    idle(3, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit go_lvl;
    @(negedge clk);

    // Reset held over two cycles
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'd10, 32'd0);
    check("rst_halt",    {31'd0, halt},   32'd0);
    check("rst_display", display,         32'd0);

    // Print
    step(1'b0, 1'b1, 1'b0, 32'd34, 32'h1234_ABCD);
    check("print_display", display, 32'h1234_ABCD);
    check("print_upd",     {31'd0, disp_upd}, 32'd1);
    check("print_halt",    {31'd0, halt},     32'd0);
    idle(1, 1'b0);
    check("print_upd_once", {31'd0, disp_upd}, 32'd0);

    // Upper bits must match: 0x1_0022 is not a print, it pauses
    step(1'b0, 1'b1, 1'b0, 32'h0001_0022, 32'hDEAD_BEEF);
    check("wide_cmp_halt",    {31'd0, halt}, 32'd1);
    check("wide_cmp_display", display,       32'h1234_ABCD);
    press();
    check("wide_cmp_resume",  {31'd0, halt}, 32'd0);

    // Pause, then GO held for 10 cycles
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    check("pause_halt", {31'd0, halt}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    cnt = 0;
    while (halt === 1'b1 && cnt < 50) begin
      step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      cnt++;
    end
    check("go_latency", cnt, S + 1);
    for (int i = 1 + cnt; i < 10; i++) step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
    idle(6, 1'b1);
    check("held_go_no_resume", {31'd0, halt}, 32'd1);
    idle(3, 1'b0);
    press();
    check("second_resume", {31'd0, halt}, 32'd0);

    // Exit, five presses ignored, CLR leaves
    step(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    check("exit_halt",   {31'd0, halt},   32'd1);
    check("exit_exited", {31'd0, exited}, 32'd1);
    for (int i = 0; i < 5; i++) press();
    step(1'b0, 1'b1, 1'b0, 32'd34, 32'h5555_5555);
    check("exit_sticky_halt",   {31'd0, halt},   32'd1);
    check("exit_sticky_exited", {31'd0, exited}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("exit_clr_halt",   {31'd0, halt},   32'd0);
    check("exit_clr_exited", {31'd0, exited}, 32'd0);

    // Collision in RUN: go_rise lands on the same edge as SYSCALL v0=5
    idle(3, 1'b0);
    idle(1 + S, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
    check("run_collision_halt", {31'd0, halt}, 32'd1);
    idle(3, 1'b1);
    check("run_collision_stays", {31'd0, halt}, 32'd1);
    // Collision in PAUSED: resume wins, SYSCALL dropped
    idle(3, 1'b0);
    idle(1 + S, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'd34, 32'hAAAA_0001);
    check("pause_collision_halt",    {31'd0, halt},     32'd0);
    check("pause_collision_display", display,           32'd0);
    check("pause_collision_upd",     {31'd0, disp_upd}, 32'd0);
`ifdef SYSCALL_STATS_EN
    check("pause_collision_count", sys_count, 32'd1);
`endif
    idle(2, 1'b0);

    // Reset mid-pause
    step(1'b0, 1'b1, 1'b0, 32'd7, 32'd0);
    check("midpause_halt", {31'd0, halt}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("midpause_clr_halt",    {31'd0, halt}, 32'd0);
    check("midpause_clr_display", display,       32'd0);
    press();
    check("midpause_go_noeffect", {31'd0, halt}, 32'd0);

    // Statistics scenario
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd34, 32'd77);
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    idle(20, 1'b0);
    idle(4, 1'b1);
    check("stats_resumed", {31'd0, halt}, 32'd0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd34, 32'd78);
`ifdef SYSCALL_STATS_EN
    check("stats_sys_count",   sys_count,   32'd3);
    check("stats_halt_cycles", halt_cycles, 32'd24);
`else
    check("stats_sys_count_off",   sys_count,   32'd0);
    check("stats_halt_cycles_off", halt_cycles, 32'd0);
`endif

    // Randomized phase
    go_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit clr, sc;
      logic [31:0] v;
      if ($urandom_range(0, 5) == 0) go_lvl = ~go_lvl;
      clr = ($urandom_range(0, 49) == 0);
      sc  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: v = 32'd34;
        4:          v = 32'd10;
        5, 6:       v = $urandom_range(0, 40);
        7:          v = $urandom;
        8:          v = 32'h8000_0022;
        default:    v = 32'h0000_010A;
      endcase
      step(clr, sc, go_lvl, v, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
